// File: rtl/alu_pkg.sv
// Shared ALU/MDU definitions: ALU function codes, multiply/divide op codes and MDU states.
package alu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    // Function select for the combinational ALU.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

endpackage

// File: rtl/alu_mdu_if.sv
// Pipeline-side bundle for the multiply/divide unit: request, HI/LO writes, status and results.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cancel;
    logic             WrHi;
    logic             WrLo;
    logic [WIDTH-1:0] WrData;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, A, B, Cancel, WrHi, WrLo, WrData,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, Op, A, B, Cancel, WrHi, WrLo, WrData,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration on the {acc, work} pair: shift-add for multiply, restoring
// trial-subtract-shift for divide.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] work_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic             div_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] work_o
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] remDiff;
    logic             fits;

    // A non-borrowing trial subtraction always leaves less than the divisor, so the low bits suffice.
    always_comb begin
        sum     = {1'b0, acc_i} + {1'b0, opnd_i};
        shifted = {acc_i, work_i[WIDTH-1]};
        fits    = (shifted >= {1'b0, opnd_i});
        remDiff = shifted[WIDTH-1:0] - opnd_i;
        if (div_i) begin
            acc_o  = fits ? remDiff : shifted[WIDTH-1:0];
            work_o = {work_i[WIDTH-2:0], fits};
        end else if (work_i[0]) begin
            acc_o  = sum[WIDTH:1];
            work_o = {sum[0], work_i[WIDTH-1:1]};
        end else begin
            acc_o  = {1'b0, acc_i[WIDTH-1:1]};
            work_o = {acc_i[0], work_i[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; fixed WIDTH+1 cycle latency per operation.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic      clk,
    input  logic      reset_n,
    alu_mdu_if.slave  bus
);
    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             div_q;
    logic             negRes_q;
    logic             negRem_q;
    logic             divZero_q;
    logic [WIDTH-1:0] aRaw_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic             busy;
    logic             startAcc;
    logic             signedOp;
    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [WIDTH-1:0] accNext;
    logic [WIDTH-1:0] workNext;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fixHi;
    logic [WIDTH-1:0] fixLo;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .work_i (work_q),
        .opnd_i (opnd_q),
        .div_i  (div_q),
        .acc_o  (accNext),
        .work_o (workNext)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Start && !bus.Cancel) state_d = CALC;
            CALC:    if (bus.Cancel) state_d = IDLE;
                     else if (count_q == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == CALC) || (state_q == FIX);
        bus.Busy   = busy;
        bus.Done   = done_q;
        bus.HI     = hi_q;
        bus.LO     = lo_q;
    end

    // The core always works on magnitudes; signs are remembered and re-applied in FIX.
    always_comb begin
        startAcc = (state_q == IDLE) && bus.Start && !bus.Cancel;
        signedOp = (bus.Op == MDU_MULT) || (bus.Op == MDU_DIV);
        aNeg     = signedOp && bus.A[WIDTH-1];
        bNeg     = signedOp && bus.B[WIDTH-1];
        aMag     = aNeg ? -bus.A : bus.A;
        bMag     = bNeg ? -bus.B : bus.B;
    end

    always_comb begin
        prod = {acc_q, work_q};
        if (negRes_q) prod = -prod;
        fixHi = prod[2*WIDTH-1:WIDTH];
        fixLo = prod[WIDTH-1:0];
        if (div_q) begin
            if (divZero_q) begin
                fixHi = aRaw_q;
                fixLo = '1;
            end else begin
                fixHi = negRem_q ? -acc_q  : acc_q;
                fixLo = negRes_q ? -work_q : work_q;
            end
        end
    end

    // HI/LO accept mthi/mtlo only when idle; a same-cycle Start still lands its result later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            div_q     <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            aRaw_q    <= '0;
            acc_q     <= '0;
            work_q    <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.WrHi) hi_q <= bus.WrData;
                    if (bus.WrLo) lo_q <= bus.WrData;
                    if (startAcc) begin
                        count_q   <= CNT_W'(WIDTH);
                        div_q     <= bus.Op[1];
                        negRes_q  <= aNeg ^ bNeg;
                        negRem_q  <= aNeg;
                        divZero_q <= (bus.B == '0);
                        aRaw_q    <= bus.A;
                        acc_q     <= '0;
                        work_q    <= aMag;
                        opnd_q    <= bMag;
                    end
                end
                CALC: begin
                    if (bus.Cancel) begin
                        count_q <= '0;
                    end else begin
                        acc_q   <= accNext;
                        work_q  <= workNext;
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!bus.Cancel) begin
                        hi_q   <= fixHi;
                        lo_q   <= fixLo;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed cases, randomized ops against an arithmetic model,
// HI/LO writes, cancel and asynchronous reset.
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    alu_mdu_if #(.WIDTH(W)) bus ();

    alu_mdu #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Spec-level result: {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa, sb;
        int          ia, ib;
        logic [31:0] q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = int'(a);
        ib = int'(b);
        case (op)
            2'b00: res = 64'(sa * sb);
            2'b01: res = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else begin
                    q   = 32'(ia / ib);
                    r   = 32'(ia % ib);
                    res = {r, q};
                end
            end
            default: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Called at a negedge; launches one op and follows it to its Done cycle (ends at that negedge).
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expHi,
                                 input logic [31:0] expLo, input bit midWrite);
        int edges;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.Start = 1'b1;
        if (midWrite) begin
            bus.WrLo   = 1'b1;
            bus.WrData = 32'hCAFE_F00D;
        end
        @(negedge clk);
        bus.Start = 1'b0;
        bus.WrLo  = 1'b0;
        checkOutput({tag, "/busyAfterStart"}, 64'(bus.Busy), 64'd1);
        checkOutput({tag, "/doneLowAfterStart"}, 64'(bus.Done), 64'd0);
        if (midWrite) checkOutput({tag, "/wrLoWithStart"}, 64'(bus.LO), 64'hCAFE_F00D);
        edges = 0;
        while (!bus.Done && edges < 3 * LAT) begin
            @(negedge clk);
            edges++;
            checkOutput({tag, "/busyAndDone"}, 64'(bus.Busy & bus.Done), 64'd0);
        end
        checkOutput({tag, "/latency"}, 64'(edges), 64'(LAT));
        checkOutput({tag, "/busyInDone"}, 64'(bus.Busy), 64'd0);
        checkOutput({tag, "/hi"}, 64'(bus.HI), 64'(expHi));
        checkOutput({tag, "/lo"}, 64'(bus.LO), 64'(expLo));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] exp;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          doneSeen;
        int          busySeen;

        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        bus.Start  = 1'b0;
        bus.Op     = 2'b00;
        bus.A      = '0;
        bus.B      = '0;
        bus.Cancel = 1'b0;
        bus.WrHi   = 1'b0;
        bus.WrLo   = 1'b0;
        bus.WrData = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset/busy", 64'(bus.Busy), 64'd0);
        checkOutput("reset/done", 64'(bus.Done), 64'd0);
        checkOutput("reset/hi", 64'(bus.HI), 64'd0);
        checkOutput("reset/lo", 64'(bus.LO), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed cases");
        applyStimulus("mult_m3x7", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        applyStimulus("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
        applyStimulus("divu_7_2", MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
        applyStimulus("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        applyStimulus("div_7_m2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        applyStimulus("div_minneg", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        applyStimulus("div_by0", MDU_DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        applyStimulus("divu_by0", MDU_DIVU, 32'h8000_0001, 32'h0, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);

        $display("[TB] randomized back-to-back ops");
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 40));
                4: rb = -32'($urandom_range(1, 9));
                default: ;
            endcase
            exp = refModel(rop, ra, rb);
            applyStimulus($sformatf("rand%0d", i), rop, ra, rb, exp[63:32], exp[31:0], (i % 5) == 0);
        end

        $display("[TB] mthi/mtlo, ignored requests and cancel");
        bus.WrHi   = 1'b1;
        bus.WrLo   = 1'b1;
        bus.WrData = 32'h1234_5678;
        @(negedge clk);
        bus.WrHi = 1'b0;
        bus.WrLo = 1'b0;
        checkOutput("wr/hi", 64'(bus.HI), 64'h1234_5678);
        checkOutput("wr/lo", 64'(bus.LO), 64'h1234_5678);
        bus.Op    = MDU_DIVU;
        bus.A     = 32'd1000;
        bus.B     = 32'd7;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        bus.Op     = MDU_MULT;
        bus.Start  = 1'b1;
        bus.WrHi   = 1'b1;
        bus.WrData = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.WrHi  = 1'b0;
        checkOutput("busy/stillBusy", 64'(bus.Busy), 64'd1);
        checkOutput("busy/wrHiIgnored", 64'(bus.HI), 64'h1234_5678);
        bus.Cancel = 1'b1;
        @(negedge clk);
        bus.Cancel = 1'b0;
        checkOutput("cancel/busy", 64'(bus.Busy), 64'd0);
        checkOutput("cancel/done", 64'(bus.Done), 64'd0);
        checkOutput("cancel/hi", 64'(bus.HI), 64'h1234_5678);
        checkOutput("cancel/lo", 64'(bus.LO), 64'h1234_5678);
        bus.Start  = 1'b1;
        bus.Cancel = 1'b1;
        @(negedge clk);
        bus.Start  = 1'b0;
        bus.Cancel = 1'b0;
        checkOutput("idleCancel/startDropped", 64'(bus.Busy), 64'd0);
        doneSeen = 0;
        busySeen = 0;
        for (int i = 0; i < LAT + 8; i++) begin
            @(negedge clk);
            if (bus.Done) doneSeen++;
            if (bus.Busy) busySeen++;
        end
        checkOutput("cancel/noLateDone", 64'(doneSeen), 64'd0);
        checkOutput("cancel/noLateBusy", 64'(busySeen), 64'd0);
        checkOutput("cancel/hiHeld", 64'(bus.HI), 64'h1234_5678);

        $display("[TB] asynchronous reset mid-operation");
        bus.Op    = MDU_MULTU;
        bus.A     = 32'hFFFF_FFFF;
        bus.B     = 32'hFFFF_FFFF;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("areset/busy", 64'(bus.Busy), 64'd0);
        checkOutput("areset/done", 64'(bus.Done), 64'd0);
        checkOutput("areset/hi", 64'(bus.HI), 64'd0);
        checkOutput("areset/lo", 64'(bus.LO), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        applyStimulus("afterReset_3x5", MDU_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        @(negedge clk);
        checkOutput("afterReset/donePulse", 64'(bus.Done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised multi-cycle multiply/divide unit that extends the combinational ALU to the MIPS `mult`, `multu`, `div` and `divu` instructions. It owns the architectural HI/LO register pair, including `mthi`/`mtlo` writes. It uses a start/busy/done handshake so that the pipeline stalls only on `mfhi`/`mflo` while the unit is busy. Both multiply and divide are iterative radix-2, one bit per cycle.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are `WIDTH` bits each.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the iteration counter.

- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `Start`: input, 1 bit. Request a new operation; accepted only in IDLE.
- `Op`: input, 2 bits. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `Start`.
- `A`: input, `WIDTH` bits. Multiplicand or dividend; sampled with `Start`.
- `B`: input, `WIDTH` bits. Multiplier or divisor; sampled with `Start`.
- `Cancel`: input, 1 bit. Abort the operation in flight (exception flush).
- `WrHi`, `WrLo`: input, 1 bit each. `mthi`/`mtlo` write strobes.
- `WrData`: input, `WIDTH` bits. Data for `WrHi`/`WrLo`.
- `Busy`: output, 1 bit. High while in CALC or FIX.
- `Done`: output, 1 bit. One-cycle pulse when HI/LO take a new result.
- `HI`, `LO`: output, `WIDTH` bits each. Architectural registers, driven directly from flops.

## Operation
- FSM states:
  - IDLE: `Start` moves to CALC. Operands are latched, `count = WIDTH`, and for signed ops operand magnitudes are taken.
  - CALC: one iteration per cycle, `count` decrements; at `count == 1` go to FIX.
  - FIX: sign correction, HI/LO write, go to IDLE.
- Multiply: `{HI,LO}` = full 2·`WIDTH`-bit product. MULT is two's-complement; MULTU is unsigned. Shift-add on magnitudes; the product is negated in FIX if the operand signs differ.
- Divide: restoring division on magnitudes.
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
- Divide boundary cases:
  - `B == 0`, both DIV and DIVU: LO = all ones, HI = `A` as sampled. Sign fix is bypassed. This result is fixed behaviour, not "undefined".
  - DIV with `A` = most-negative and `B` = −1: LO = most-negative, HI = 0. No flag is raised.
- `Start` while `Busy` is ignored; there is no queueing.
- `Cancel`:
  - In CALC or FIX: return to IDLE at the next edge. HI/LO are unchanged and `Done` is not asserted.
  - In IDLE: no effect. `Cancel` together with `Start` in IDLE: `Start` is dropped.
- `WrHi`/`WrLo`:
  - In IDLE: written at the next edge. Both may be asserted in the same cycle.
  - While `Busy`: ignored.
  - In IDLE together with `Start`: the write lands, and is later overwritten by the result.
- Reset, asserted at any time including mid-operation: state IDLE, `count` 0, HI = LO = 0, `Busy` = 0, `Done` = 0.

## Timing
- `Start` sampled at edge k:
  - `Busy` = 1 from after edge k.
  - CALC occupies `WIDTH` cycles, then FIX occupies one cycle.
  - At edge k+`WIDTH`+1, HI/LO are updated, `Busy` falls, and `Done` = 1 for exactly that cycle.
- Latency is `WIDTH`+1 cycles for every op and every operand value, including divide-by-zero. Operand values never cause an early exit.
- A new `Start` is accepted in the `Done` cycle, giving back-to-back throughput of one op per `WIDTH`+2 cycles.
- `Busy` and `Done` are never high together.
- `Busy` is the stall condition for `mfhi`/`mflo` and for a new `mult`/`div`.

## Structure
- Shared package `alu_pkg`:
  - `mdu_op_t` (2-bit enum: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU).
  - `mdu_state_t` (IDLE, CALC, FIX).
  - The existing ALUFunc constants are relocated here.
- Sub-module `mdu_step`: combinational, one iteration for either mode (add-shift or trial-subtract-shift) on {acc, operand, mode}. The top level contains only the FSM, counter, sign handling and HI/LO registers.

## Test plan
All cases at `WIDTH` = 32.
1. MULT, A = 0xFFFFFFFD (−3), B = 7 → `Done` 33 cycles after the `Start` edge; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
2. MULTU, A = B = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. Then DIVU 7/2 → LO = 3, HI = 1.
3. DIV −7/2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Then DIV 7/−2 → LO = 0xFFFFFFFD, HI = 1.
4. Divide boundaries:
   - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
   - DIV 0xFFFFFFFB / 0 → LO = 0xFFFFFFFF, HI = 0xFFFFFFFB.
   - Latency is still 33 cycles.
5. HI = LO = 0x12345678 via `WrHi`/`WrLo`; start DIVU; at cycle 10:
   - Pulse `Start` and `WrHi` → both ignored.
   - Pulse `Cancel` → `Busy` low after the next edge, no `Done`, HI/LO still 0x12345678.
6. Assert `reset_n` = 0 asynchronously mid-CALC (between edges) → `Busy` = 0 and HI = LO = 0 immediately. After release, a MULTU 3×5 completes normally with LO = 15.
